// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and the default datapath width.
package muldiv_pkg;

   localparam int WIDTH_DEF = 32;

   typedef enum logic [2:0] {
      MULT  = 3'd0,
      MULTU = 3'd1,
      DIV   = 3'd2,
      DIVU  = 3'd3,
      MTHI  = 3'd4,
      MTLO  = 3'd5
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle datapath on unsigned magnitudes: shift-add multiply and,
// when MULDIV_DIV_EN is defined, restoring shift-subtract divide.
module muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
`ifdef MULDIV_DIV_EN
   input  logic             is_div,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi_part,
   output logic [WIDTH-1:0] lo_part
);

   logic [WIDTH-1:0] b_r;
   logic [WIDTH:0]   add_sum;
   logic [WIDTH-1:0] hi_nxt;
   logic [WIDTH-1:0] lo_nxt;
`ifdef MULDIV_DIV_EN
   logic             is_div_r;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
`endif

   // hi_part/lo_part are the product halves for multiply and the
   // remainder/quotient pair for divide.
   // NOTE: every always_comb output gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      add_sum = {1'b0, hi_part} + (lo_part[0] ? {1'b0, b_r} : '0);
      hi_nxt  = add_sum[WIDTH:1];
      lo_nxt  = {add_sum[0], lo_part[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
      shifted = {hi_part, lo_part[WIDTH-1]};
      diff    = shifted - {1'b0, b_r};
      if (is_div_r) begin
         if (!diff[WIDTH]) begin
            hi_nxt = diff[WIDTH-1:0];
            lo_nxt = {lo_part[WIDTH-2:0], 1'b1};
         end else begin
            hi_nxt = shifted[WIDTH-1:0];
            lo_nxt = {lo_part[WIDTH-2:0], 1'b0};
         end
      end
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hi_part  <= '0;
         lo_part  <= '0;
         b_r      <= '0;
`ifdef MULDIV_DIV_EN
         is_div_r <= 1'b0;
`endif
      end else if (load) begin
         hi_part  <= '0;
         lo_part  <= a;
         b_r      <= b;
`ifdef MULDIV_DIV_EN
         is_div_r <= is_div;
`endif
      end else if (step) begin
         hi_part  <= hi_nxt;
         lo_part  <= lo_nxt;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// MIPS-style HI/LO multiply/divide unit: FSM, sign handling and HI/LO
// registers around muldiv_iter. Define MULDIV_DIV_EN to include DIV/DIVU.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             op_signed;
   logic [WIDTH-1:0] rs_mag, rt_mag;
   logic             neg_lo, neg_hi;
   logic [WIDTH-1:0] iter_hi, iter_lo;
   logic [2*WIDTH-1:0] prod_raw, prod_fix;
   logic [WIDTH-1:0] res_hi, res_lo;
`ifdef MULDIV_DIV_EN
   logic             is_div;
   logic             is_div_r;
   logic             div0_r;
   logic [WIDTH-1:0] rs_r;

   assign is_div    = (op == DIV) || (op == DIVU);
   assign op_signed = (op == MULT) || (op == DIV);
`else
   assign op_signed = (op == MULT);
`endif

   assign rs_mag = (op_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
   assign rt_mag = (op_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (op == MULT || op == MULTU) begin
                  accept    = 1'b1;
                  state_nxt = RUN;
               end
`ifdef MULDIV_DIV_EN
               else if (is_div) begin
                  accept    = 1'b1;
                  state_nxt = (rt_data == '0) ? FIX : RUN;
               end
`endif
            end
         end
         RUN:     if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (accept),
      .step    (state == RUN),
`ifdef MULDIV_DIV_EN
      .is_div  (is_div),
`endif
      .a       (rs_mag),
      .b       (rt_mag),
      .hi_part (iter_hi),
      .lo_part (iter_lo)
   );

   // neg_lo is the product/quotient sign, neg_hi the remainder sign (dividend's).
   always_comb begin
      prod_raw = {iter_hi, iter_lo};
      prod_fix = neg_lo ? -prod_raw : prod_raw;
      res_hi   = prod_fix[2*WIDTH-1:WIDTH];
      res_lo   = prod_fix[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
      if (is_div_r) begin
         if (div0_r) begin
            res_hi = rs_r;
            res_lo = '1;
         end else begin
            res_hi = neg_hi ? -iter_hi : iter_hi;
            res_lo = neg_lo ? -iter_lo : iter_lo;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         neg_lo      <= 1'b0;
         neg_hi      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
`ifdef MULDIV_DIV_EN
         is_div_r    <= 1'b0;
         div0_r      <= 1'b0;
         rs_r        <= '0;
`endif
      end else begin
         state       <= state_nxt;
         cnt         <= (state == RUN) ? cnt + 1'b1 : '0;
         busy        <= (state_nxt != IDLE);
         done        <= (state == FIX);
`ifdef MULDIV_DIV_EN
         div_by_zero <= (state == FIX) && div0_r;
`else
         div_by_zero <= 1'b0;
`endif
         if (accept) begin
            neg_lo   <= op_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            neg_hi   <= op_signed && rs_data[WIDTH-1];
`ifdef MULDIV_DIV_EN
            is_div_r <= is_div;
            div0_r   <= is_div && (rt_data == '0);
            rs_r     <= rs_data;
`endif
         end
         if (state == FIX) begin
            hi <= res_hi;
            lo <= res_lo;
         end else if (state == IDLE && start) begin
            if (op == MTHI) hi <= rs_data;
            if (op == MTLO) lo <= rs_data;
         end
      end
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width.
REQ-002 SHALL have parameter CNT_W, default 6, iteration counter width (must hold WIDTH).
REQ-003 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port start, input, 1, requests an operation this cycle.
REQ-006 SHALL have port op, input, 3, operation code from muldiv_pkg: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 SHALL have port rs_data, input, WIDTH, register-file read_data1 (multiplicand/dividend/move source).
REQ-008 SHALL have port rt_data, input, WIDTH, register-file read_data2 (multiplier/divisor).
REQ-009 SHALL have port busy, output, 1, high while an iterative operation runs.
REQ-010 SHALL have port done, output, 1, one-cycle pulse when HI/LO hold a new MULT/DIV result.
REQ-011 SHALL have port div_by_zero, output, 1, qualified by done; high when the completed divide had rt_data=0.
REQ-012 SHALL have ports hi and lo, output, WIDTH each, architectural HI/LO registers.

Function
REQ-013 SHALL use FSM states IDLE, RUN, FIX; FIX applies the sign correction and writes HI/LO.
REQ-014 SHALL accept start only in IDLE; start in RUN or FIX SHALL be ignored with no side effect.
REQ-015 SHALL on an accepted MULT/MULTU/DIV/DIVU latch operands, set busy on the next edge, and go to RUN with counter=0.
REQ-016 SHALL in RUN do one shift-add (multiply) or restoring shift-subtract (divide) step per cycle on operand magnitudes, for WIDTH cycles.
REQ-017 SHALL after WIDTH RUN cycles go to FIX; in FIX apply the signs, write HI/LO, drop busy and assert done for exactly that cycle, then return to IDLE.
REQ-018 SHALL give start-to-done latency WIDTH+2 edges (34 for WIDTH=32), with the start cycle counted as edge 0.
REQ-019 SHALL make multiply produce {HI,LO} = the full 2*WIDTH product; MULT is signed and MULTU is unsigned.
REQ-020 SHALL make divide produce LO=quotient and HI=remainder; signed quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-021 SHALL on divide with rt_data=0 skip RUN, go directly to FIX, set HI=rs_data, LO=all-ones, and assert div_by_zero with done.
REQ-022 SHALL on signed DIV of most-negative by -1 produce LO=most-negative and HI=0, with no flag.
REQ-023 SHALL on MTHI/MTLO accepted in IDLE write rs_data into hi/lo on the next edge, with no busy and no done.
REQ-024 SHALL hold hi/lo stable at all times except in FIX and on an MTHI/MTLO write.

Reset
REQ-025 SHALL on rst_n=0 at a rising edge force state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, div_by_zero=0.
REQ-026 SHALL on reset during RUN or FIX abort the operation with no HI/LO update, and give rst_n priority over start.

Configuration
REQ-027 SHALL with macro MULDIV_DIV_EN defined support DIV/DIVU as specified.
REQ-028 SHALL with MULDIV_DIV_EN undefined treat DIV/DIVU as no-ops: no busy, no done, HI/LO unchanged, and no divide datapath synthesized.

Structure
REQ-029 SHALL place the op encodings, the FSM state enum, and the WIDTH default constant in shared package muldiv_pkg.
REQ-030 SHALL put the iterative shift/add/subtract datapath in one sub-module, muldiv_iter; the FSM, sign handling and HI/LO stay in muldiv_unit.

Verification
REQ-031 SHALL cover MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> done at edge 34, HI=0xFFFFFFFE, LO=0x00000001.
REQ-032 SHALL cover MULT rs=-3, rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-033 SHALL cover DIV rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIVU rs=100, rt=0 -> done at edge 2, div_by_zero=1, HI=100, LO=0xFFFFFFFF.
REQ-034 SHALL cover DIV rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0, div_by_zero=0.
REQ-035 SHALL cover MTLO 0x1234 while busy -> ignored and result unchanged; MTHI 0xABCD in IDLE -> hi=0xABCD next edge, done stays 0.
REQ-036 SHALL cover rst_n low at RUN cycle 10 of a MULT -> busy=0, hi=lo=0 next edge, and no done pulse afterward.
